// File: rtl/buffer_arb_pkg.sv
// buffer_arb_pkg: shared state type and round-robin helpers for buffer_arbiter.
package buffer_arb_pkg;
    typedef enum logic {EMPTY, FULL} arb_state_t;
    localparam int MAXREQ = 32;
    localparam int MAXSW = 5;
    function automatic logic [MAXREQ-1:0] onehot(input int unsigned idx);
        return MAXREQ'(1) << idx;
    endfunction
    // First set bit at or after rrPtr, wrapping at nreq; rrPtr is always below nreq.
    function automatic logic [MAXSW-1:0] rr_pick(input logic [MAXREQ-1:0] effReq, input int unsigned rrPtr,
                                                  input int unsigned nreq);
        logic [MAXSW-1:0] win;
        logic found;
        int unsigned idx;
        win = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < MAXREQ; k++) begin
            if (k < nreq) begin
                idx = rrPtr + k;
                if (idx >= nreq) idx = idx - nreq;
                if (!found && effReq[idx[MAXSW-1:0]]) begin
                    win = idx[MAXSW-1:0];
                    found = 1'b1;
                end
            end
        end
        return win;
    endfunction
endpackage

// File: rtl/buffer.sv
// buffer: enable-loaded data register with synchronous clear.
module buffer #(
    parameter int Buffer_size = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [Buffer_size-1:0] d,
    output logic [Buffer_size-1:0] q
);
    always_ff @(posedge clk)
        if (rst) q <= '0;
        else if (en) q <= d;
endmodule

// File: rtl/buffer_arbiter_rr_picker.sv
// rr_picker: combinational round-robin selector over the effective request vector.
module rr_picker import buffer_arb_pkg::*; #(
    parameter int NREQ = 4,
    localparam int SW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] effReq,
    input  logic [SW-1:0]   rrPtr,
    output logic [SW-1:0]   winner,
    output logic            anyReq
);
    assign winner = SW'(rr_pick(MAXREQ'(effReq), 32'(rrPtr), NREQ));
    assign anyReq = |effReq;
endmodule

// File: rtl/buffer_arbiter.sv
// buffer_arbiter: round-robin sharing of one buffer register among NREQ producers with a valid/ready output.
module buffer_arbiter import buffer_arb_pkg::*; #(
    parameter int BW = 4,
    parameter int NREQ = 4,
    localparam int SW = $clog2(NREQ)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NREQ-1:0]  req,
    input  logic [NREQ*BW-1:0] data_in,
    output logic [NREQ-1:0]  grant,
    output logic [BW-1:0]    out_data,
    output logic [SW-1:0]    out_src,
    output logic             out_valid,
    input  logic             out_ready
);
    arb_state_t state;
    logic [SW-1:0] rrPtr, winner;
    logic [NREQ-1:0] effReq;
    logic anyReq, loadEn;
    // Last cycle's winner may still hold req high; mask it so it is not picked twice.
    assign effReq = req & ~grant;
    assign loadEn = anyReq && (state == EMPTY || out_ready);
    assign out_valid = (state == FULL);
    rr_picker #(.NREQ(NREQ)) picker (
        .effReq(effReq),
        .rrPtr (rrPtr),
        .winner(winner),
        .anyReq(anyReq)
    );
    buffer #(.Buffer_size(BW)) dataReg (
        .clk(clk),
        .rst(rst),
        .en (loadEn),
        .d  (data_in[int'(winner)*BW +: BW]),
        .q  (out_data)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= EMPTY;
            grant   <= '0;
            out_src <= '0;
            rrPtr   <= '0;
        end else begin
            grant <= loadEn ? NREQ'(onehot(32'(winner))) : '0;
            if (loadEn) begin
                out_src <= winner;
                rrPtr   <= (winner == SW'(NREQ-1)) ? '0 : winner + 1'b1;
                state   <= FULL;
            end else if (out_ready) begin
                state <= EMPTY;
            end
        end
    end
endmodule

// File: doc/buffer_arbiter.md
Name: buffer_arbiter

Overview:
- Round-robin arbiter that shares one `buffer` register (Buffer_size = BW) among NREQ producers.
- Picks one pending requester and pulses `en` on the shared buffer to capture that requester's word.
- Acknowledges the winner with a one-cycle grant.
- Presents the held word downstream on a valid/ready handshake; the slot is freed when the consumer accepts the word.

Parameters:
- BW, 4, data width of each requester word and of the shared buffer.
- NREQ, 4, number of requesters; must be at least 2.
- SW, $clog2(NREQ), width of the source index (derived, not overridable).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  NREQ  per-requester request; the requester holds it high until it sees its grant bit.
- data_in  in  NREQ*BW  flattened requester words; requester i occupies bits [i*BW +: BW]; must be stable while req[i]=1.
- grant  out  NREQ  one-hot acknowledge, high for exactly one cycle after capture.
- out_data  out  BW  shared buffer contents.
- out_src  out  SW  index of the requester whose word is in out_data.
- out_valid  out  1  buffer holds an unconsumed word.
- out_ready  in  1  consumer accepts out_data in any cycle where out_valid=1 and out_ready=1.

Behaviour:
- Reset (rst=1 at an edge):
  - State goes to EMPTY; out_valid=0, grant=0, out_src=0, rr_ptr=0.
  - The shared buffer's rst is tied to rst, so out_data=0.
  - Reset mid-operation discards the held word; no grant is issued for it.
- Masked request: eff_req = req & ~grant. The requester granted in the previous edge is never re-selected while its req is still high.
- Winner selection:
  - The winner is the first set bit of eff_req at or after index rr_ptr, wrapping from NREQ-1 to 0.
  - This is combinational; the winner is undefined when eff_req=0.
- Load condition: load = |eff_req && (state==EMPTY || out_ready).
- On a load edge:
  - buffer en=1, capturing data_in[winner].
  - out_src <= winner.
  - grant <= onehot(winner), high for the next cycle only.
  - rr_ptr <= (winner+1) mod NREQ.
  - state <= FULL.
- Non-load edges: buffer en=0 (contents held); grant <= 0.
- State EMPTY: out_valid=0.
  - With no eff_req, stay EMPTY.
  - Latency from req rising to out_valid=1 and grant=1 is exactly 1 cycle.
- State FULL: out_valid=1 and out_data is stable.
  - out_ready=1 with a load: the current word is consumed and the new one loaded in the same edge; stay FULL. This gives 1 word/cycle sustained throughput.
  - out_ready=1 with no eff_req: go to EMPTY.
  - out_ready=0: hold everything and accept no new request (backpressure); rr_ptr is unchanged.
- rr_ptr advances only on a load and wraps modulo NREQ. If NREQ is not a power of two, the value NREQ-1 wraps to 0, never to NREQ.
- Fairness: with all requesters continuously requesting and out_ready=1, grants rotate 0,1,...,NREQ-1,0. No requester waits more than NREQ loads.
- A requester whose req drops before it is selected is simply skipped. Stale data is never captured.

Decomposition:
- Shared package buffer_arb_pkg holds:
  - enum arb_state_t {EMPTY, FULL};
  - a function onehot(idx) returning NREQ bits;
  - a function rr_pick(eff_req, rr_ptr) returning an SW-bit index.
- The data register is the existing `buffer` module, instantiated with Buffer_size=BW, rst, clk, en=load, input = selected word.
- One natural sub-module: rr_picker, a purely combinational round-robin selector (inputs eff_req and rr_ptr; outputs winner and any_req). It can be unit-tested on its own.

Test Plan:
- Reset, then req=0001 with data_in word0=3 -> next cycle grant=0001, out_valid=1, out_data=3, out_src=0; apply out_ready=1 -> out_valid=0 next cycle.
- req=1111, words 3,4,5,6, out_ready=1 held -> consecutive cycles carry out_data 3,4,5,6,3 with out_src 0,1,2,3,0, and grant is one-hot in each cycle.
- FULL with out_data=3, out_ready=0 for 3 cycles, req[1]=1 with word 4 -> out_data stays 3, grant stays 0; out_ready=1 -> next cycle out_data=4, grant=0010.
- rr_ptr=2 (after a grant to 1), req=0011 -> winner 0 (wraps past 2 and 3), grant=0001; requester 1 wins on the following load.
- rst=1 asserted while FULL with out_data=4 -> next cycle out_valid=0, out_data=0, grant=0; the first post-reset load with req=1000 goes to requester 3, and the next load with req=1001 goes to requester 0, confirming rr_ptr restarted at 0 and wrapped from 3.
- NREQ=3 build, req=111, out_ready=1 -> out_src sequence 0,1,2,0,1; out_src never shows 3.
